// File: rtl/cu_fetch_if.sv
// ThetaCore IF-stage bus: instruction memory read port
// plus the fetched-word handoff toward the decoder.
interface cu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        Fetch_ready;
  logic [31:0] Fetch_IR;
  logic [31:0] Fetch_PC;
  logic        decode_accept;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output Fetch_ready,
    output Fetch_IR,
    output Fetch_PC,
    input  decode_accept
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  Fetch_ready,
    input  Fetch_IR,
    input  Fetch_PC,
    output decode_accept
  );
endinterface

// File: rtl/cu_fetch.sv
// ThetaCore instruction-fetch stage: owns the PC, issues one
// outstanding imem read, buffers the word for the decoder.
module cu_fetch #(
  parameter int unsigned IMEM_DEPTH_WORDS = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        IF_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  cu_fetch_if.master  bus
);

  localparam logic [32:0] PC_LIMIT =
    33'(IMEM_DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] req_q;
  logic [31:0] req_d;
  logic [31:0] ir_q;
  logic [31:0] ir_d;
  logic [31:0] fpc_q;
  logic [31:0] fpc_d;
  logic        disc_q;
  logic        disc_d;
  logic        issue;
  logic [31:0] issue_pc;
  logic        hold_ok;
  logic        hs;

  function automatic logic pc_legal(
    input logic [31:0] a
  );
    return (a[1:0] == 2'b00) &&
           ({1'b0, a} < PC_LIMIT);
  endfunction

  // A redirect in HOLD masks ready so no handoff can slip through.
  assign hold_ok = (state_q == S_HOLD) &&
                   !IF_stall && !redirect_valid;
  assign hs      = hold_ok && bus.decode_accept;

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= '0;
      ir_q    <= '0;
      fpc_q   <= '0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      ir_q    <= ir_d;
      fpc_q   <= fpc_d;
      disc_q  <= disc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    ir_d     = ir_q;
    fpc_d    = fpc_q;
    disc_d   = disc_q;
    issue    = 1'b0;
    issue_pc = pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          issue    = 1'b1;
          issue_pc = redirect_pc;
        end else if (fetch_start && !IF_stall) begin
          issue    = 1'b1;
          issue_pc = pc_q;
        end
      end

      S_REQ: begin
        if (bus.imem_ack) begin
          disc_d = 1'b0;
          if (redirect_valid) begin
            pc_d     = redirect_pc;
            issue    = 1'b1;
            issue_pc = redirect_pc;
          end else if (disc_q) begin
            issue    = 1'b1;
            issue_pc = pc_q;
          end else begin
            ir_d    = bus.imem_rdata;
            fpc_d   = req_q;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          // keep imem_addr stable; the stale word is dropped on ack
          pc_d   = redirect_pc;
          disc_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          issue    = 1'b1;
          issue_pc = redirect_pc;
          state_d  = S_IDLE;
        end else if (hs) begin
          pc_d = pc_q + 32'd4;
          if (fetch_start) begin
            issue    = 1'b1;
            issue_pc = pc_q + 32'd4;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase

    if (issue) begin
      if (pc_legal(issue_pc)) begin
        state_d = S_REQ;
        req_d   = issue_pc;
      end else begin
        state_d = S_ERR;
      end
    end
  end

  always_comb begin
    bus.imem_req    = 1'b0;
    bus.imem_addr   = '0;
    bus.Fetch_ready = 1'b0;
    fetch_err       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.imem_req = 1'b0;
      end
      S_REQ: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = req_q;
      end
      S_HOLD: begin
        bus.Fetch_ready = hold_ok;
      end
      S_ERR: begin
        fetch_err = 1'b1;
      end
      default: begin
        fetch_err = 1'b1;
      end
    endcase
  end

  assign bus.Fetch_IR = ir_q;
  assign bus.Fetch_PC = fpc_q;

endmodule

// File: tb/tb_cu_fetch.sv
// Bench for cu_fetch: directed scenarios then randomized
// traffic against a transaction-level reference model.
module tb_cu_fetch;

  localparam int DEPTH = 128;

  logic        soc_clk;
  logic        reset;
  logic        fetch_start;
  logic        IF_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  cu_fetch_if bus ();

  cu_fetch #(
    .IMEM_DEPTH_WORDS(DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .soc_clk(soc_clk),
    .reset(reset),
    .fetch_start(fetch_start),
    .IF_stall(IF_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_err(fetch_err),
    .bus(bus)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    int          cyc;
  } hs_t;

  hs_t hs[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  wcnt    = 0;
  int  wait_n  = 0;
  bit  rand_mem = 1'b0;

  // reference model: one outstanding read, one buffered word
  bit          m_err  = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_full = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_ir   = 32'h0;
  logic [31:0] m_fpc  = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a << 1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit          go;
    logic [31:0] tgt;
    go  = 1'b0;
    tgt = m_pc;
    if (reset) begin
      m_err = 0; m_pend = 0; m_drop = 0; m_full = 0;
      m_pc = 0; m_addr = 0; m_ir = 0; m_fpc = 0;
    end else if (!m_err) begin
      if (m_pend) begin
        if (bus.imem_ack) begin
          m_pend = 0;
          if (redirect_valid) begin
            m_drop = 0; m_pc = redirect_pc;
            go = 1; tgt = redirect_pc;
          end else if (m_drop) begin
            m_drop = 0; go = 1; tgt = m_pc;
          end else begin
            m_ir = bus.imem_rdata; m_fpc = m_addr;
            m_full = 1;
          end
        end else if (redirect_valid) begin
          m_pc = redirect_pc; m_drop = 1;
        end
      end else if (redirect_valid) begin
        m_full = 0; m_pc = redirect_pc;
        go = 1; tgt = redirect_pc;
      end else if (m_full) begin
        if (!IF_stall && bus.decode_accept) begin
          m_full = 0; m_pc = m_pc + 4;
          go = fetch_start; tgt = m_pc;
        end
      end else if (fetch_start && !IF_stall) begin
        go = 1; tgt = m_pc;
      end
      if (go) begin
        if (tgt % 4 == 0 && tgt < 4 * DEPTH) begin
          m_pend = 1; m_addr = tgt;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic tick();
    bit req_now;
    bit ack_now;
    if (bus.imem_req && wcnt >= wait_n) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = memf(bus.imem_addr);
    end else begin
      bus.imem_ack   = rand_mem && !bus.imem_req &&
                       ($urandom_range(0, 9) == 0);
      bus.imem_rdata = $urandom;
    end
    #1;
    chk("imem_req", bus.imem_req, m_pend);
    chk("imem_addr", bus.imem_addr, m_pend ? m_addr : 0);
    chk("fetch_ready", bus.Fetch_ready,
        m_full && !IF_stall && !redirect_valid);
    chk("fetch_err", fetch_err, m_err);
    if (!m_err) begin
      chk("fetch_ir", bus.Fetch_IR, m_ir);
      chk("fetch_pc", bus.Fetch_PC, m_fpc);
    end
    if (bus.Fetch_ready)
      chk("ir_vs_mem", bus.Fetch_IR, memf(bus.Fetch_PC));
    if (bus.Fetch_ready && bus.decode_accept)
      hs.push_back('{bus.Fetch_PC, bus.Fetch_IR, cyc});
    model_step();
    req_now = bus.imem_req;
    ack_now = bus.imem_ack;
    @(posedge soc_clk);
    #1;
    if (reset) begin
      wcnt = 0;
    end else if (req_now && ack_now) begin
      wcnt = 0;
      if (rand_mem) wait_n = $urandom_range(0, 3);
    end else if (req_now) begin
      wcnt++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int  c0;
    int  n;
    int  nreq;
    bit  found;
    logic [31:0] t;

    reset = 1'b1;
    fetch_start = 1'b0;
    IF_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.decode_accept = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    @(posedge soc_clk);
    #1;
    do_reset();

    // reset state
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_ready", bus.Fetch_ready, 0);
    chk("rst_ir", bus.Fetch_IR, 0);
    chk("rst_pc", bus.Fetch_PC, 0);
    chk("rst_err", fetch_err, 0);

    // sequential fetch, zero-wait memory, accept always high
    fetch_start = 1'b1;
    bus.decode_accept = 1'b1;
    wait_n = 0;
    hs.delete();
    c0 = cyc;
    for (int i = 0; i < 7; i++) tick();
    chk("seq_count", hs.size(), 3);
    if (hs.size() >= 3) begin
      chk("seq_latency", hs[0].cyc - c0, 2);
      for (int i = 0; i < 3; i++) begin
        chk("seq_pc", hs[i].pc, 4 * i);
        chk("seq_ir", hs[i].ir, 8 * i);
        if (i > 0) chk("seq_gap", hs[i].cyc - hs[i-1].cyc, 2);
      end
    end

    // three wait states
    do_reset();
    wait_n = 3;
    hs.delete();
    nreq = 0;
    c0 = cyc;
    for (int i = 0; i < 20 && hs.size() == 0; i++) begin
      if (bus.imem_req) begin
        nreq++;
        chk("wait_addr", bus.imem_addr, 0);
      end
      tick();
    end
    chk("wait_hs", hs.size(), 1);
    chk("wait_reqcyc", nreq, 4);
    if (hs.size() > 0) chk("wait_latency", hs[0].cyc - c0, 5);

    // redirect while the read of 0x8 is outstanding
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h8) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rq_found", found, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    hs.delete();
    for (int i = 0; i < 40 && hs.size() == 0; i++) tick();
    chk("rq_hs", hs.size(), 1);
    if (hs.size() > 0) begin
      chk("rq_pc", hs[0].pc, 32'h40);
      chk("rq_ir", hs[0].ir, 32'h80);
    end

    // redirect in HOLD together with decode_accept
    do_reset();
    wait_n = 0;
    bus.decode_accept = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Fetch_ready) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rh_found", found, 1);
    bus.decode_accept = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    n = hs.size();
    tick();
    redirect_valid = 1'b0;
    bus.decode_accept = 1'b0;
    chk("rh_nohs", hs.size(), n);
    chk("rh_req", bus.imem_req, 1);
    chk("rh_addr", bus.imem_addr, 32'h100);

    // stall in HOLD for four cycles with accept high
    for (int i = 0; i < 10 && !bus.Fetch_ready; i++) tick();
    chk("st_ready0", bus.Fetch_ready, 1);
    IF_stall = 1'b1;
    bus.decode_accept = 1'b1;
    n = hs.size();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_ready", bus.Fetch_ready, 0);
      chk("st_pc", bus.Fetch_PC, 32'h100);
      chk("st_ir", bus.Fetch_IR, 32'h200);
      tick();
    end
    chk("st_nohs", hs.size(), n);
    IF_stall = 1'b0;
    tick();
    chk("st_onehs", hs.size(), n + 1);
    if (hs.size() > n) begin
      chk("st_hs_pc", hs[n].pc, 32'h100);
      chk("st_hs_ir", hs[n].ir, 32'h200);
    end

    // illegal redirect target
    fetch_start = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    chk("e1_err", fetch_err, 1);
    chk("e1_req", bus.imem_req, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    fetch_start = 1'b1;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("e1_sticky", fetch_err, 1);
    chk("e1_quiet", bus.imem_req, 0);
    do_reset();
    chk("e1_clear", fetch_err, 0);

    // run off the end of instruction memory
    hs.delete();
    for (int i = 0; i < 400 && !fetch_err; i++) tick();
    chk("e2_err", fetch_err, 1);
    chk("e2_count", hs.size(), DEPTH);
    if (hs.size() > 0) chk("e2_last", hs[$].pc, 32'h1FC);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("e2_sticky", fetch_err, 1);

    // randomized traffic
    do_reset();
    rand_mem = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      fetch_start = ($urandom_range(0, 9) != 0);
      IF_stall = ($urandom_range(0, 4) == 0);
      bus.decode_accept = ($urandom_range(0, 4) < 3);
      reset = ($urandom_range(0, 149) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      t = 32'($urandom_range(0, 130)) << 2;
      if ($urandom_range(0, 49) == 0)
        t[1:0] = 2'($urandom_range(1, 3));
      redirect_pc = t;
      tick();
    end
    reset = 1'b0;
    redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_fetch.md
# cu_fetch

Instruction-fetch (IF) stage of the ThetaCore control unit, directly upstream of the instruction decoder. Owns the program counter and issues single-outstanding word reads to instruction memory. Holds each fetched word with its PC in an output buffer and hands it to the decoder over a valid/accept handshake. Also handles PC redirects from branch/jump resolution and flags illegal fetch addresses.

## Interface
Parameters:
- IMEM_DEPTH_WORDS, 128, instruction memory size in 32-bit words; legal PC range is 0 to 4*IMEM_DEPTH_WORDS-4.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- soc_clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- fetch_start  in  1  level enable; a new request is started only while high.
- IF_stall  in  1  freeze: no new request, no handoff.
- redirect_valid  in  1  one-cycle pulse: replace PC with redirect_pc.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  32  byte address; stable while imem_req is high.
- imem_ack  in  1  read complete; ignored unless imem_req is high; may arrive in the first request cycle.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- Fetch_ready  out  1  Fetch_IR/Fetch_PC valid for the decoder.
- Fetch_IR  out  32  fetched instruction.
- Fetch_PC  out  32  address of Fetch_IR.
- decode_accept  in  1  decoder consumes the word when Fetch_ready is also high.
- fetch_err  out  1  sticky illegal-fetch flag.

## Operation
- State machine states: IDLE, REQ, HOLD, ERR. Internal registers: pc, req_addr, discard flag.
- Legality check, applied whenever a request would be issued: the address is illegal if pc[1:0]!=0 or pc >= 4*IMEM_DEPTH_WORDS.
  - Illegal: go to ERR with fetch_err=1; no request is issued.
- IDLE:
  - fetch_start=1, IF_stall=0, pc legal: go to REQ, req_addr<=pc.
  - Otherwise remain in IDLE.
- REQ:
  - imem_req=1, imem_addr=req_addr.
  - On imem_ack with discard=0: Fetch_IR<=imem_rdata, Fetch_PC<=req_addr, go to HOLD.
  - On imem_ack with discard=1: drop the data, clear discard, issue a request for pc (legality-checked) next cycle.
- HOLD:
  - Fetch_ready=1 unless IF_stall is high.
  - On handshake (Fetch_ready & decode_accept): pc<=pc+4, then REQ on pc+4 if fetch_start, else IDLE.
- Redirect (priority: reset > redirect > stall > normal):
  - In IDLE or HOLD: pc<=redirect_pc; the buffered word is dropped; no handshake occurs that cycle even if decode_accept is high; next cycle a request for redirect_pc (legality-checked).
  - In REQ without ack: pc<=redirect_pc, discard<=1. imem_addr stays unchanged until the ack.
  - In REQ with ack in the same cycle: the data is dropped; next cycle a request for redirect_pc.
- IF_stall:
  - An outstanding request still completes.
  - The HOLD buffer is retained with Fetch_ready forced low.
  - IDLE does not advance.
- ERR:
  - fetch_err=1 and all outputs are quiet.
  - Redirects are ignored; only reset leaves ERR.
- PC arithmetic: pc+4 is modulo 2^32. A wrap to 0 is legal. Reaching 4*IMEM_DEPTH_WORDS triggers ERR at the next issue.

## Timing
- Reset values: imem_req=0, imem_addr=0, Fetch_ready=0, Fetch_IR=0, Fetch_PC=0, fetch_err=0, pc=RESET_PC, discard=0, state IDLE.
- Reset asserted mid-request abandons the request. imem_req is low in the cycle after reset is sampled.
- Latency: fetch_start is sampled in cycle 0, imem_req is high in cycle 1, ack in cycle 1 gives Fetch_ready=1 in cycle 2.
- Throughput: zero-wait memory with accept asserted immediately gives 1 instruction per 2 cycles.
- Fetch_IR/Fetch_PC change only on a non-discarded ack. They hold their values after Fetch_ready drops.
- fetch_err rises the cycle after the illegal issue attempt.

## Test plan
- Sequential fetch: reset, fetch_start=1, zero-wait memory returning addr*2, accept always high -> handoffs (PC,IR)=(0,0),(4,8),(8,16), one every 2 cycles.
- Wait states: ack 3 cycles after req -> imem_addr stable for all 3 cycles; Fetch_ready follows the ack by 1 cycle.
- Redirect during an outstanding request: redirect_pc=0x40 while awaiting the ack for 0x8 -> the 0x8 data is never presented; next Fetch_PC=0x40.
- Redirect in HOLD together with decode_accept -> no handshake that cycle; the next request address is the redirect target.
- Stall: IF_stall=1 in HOLD for 4 cycles with accept high -> Fetch_ready=0 and the buffer is unchanged; on release it handshakes once with the same PC/IR.
- Errors: redirect to 0x202 -> fetch_err=1, no imem_req. Separately, with IMEM_DEPTH_WORDS=128, running to pc=0x200 -> fetch_err=1. In both cases fetch_err stays high until reset.
